// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM status, word type, arbiter state and latched request.
// Default arbitration constants live here so the arbiter and its users agree on them.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, DONE} arb_state_t;

    localparam int DSTREAK_MAX_DEF = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Request captured at arbitration; drives the RAM port for the whole grant.
    typedef struct packed {
        logic  wen;
        word_t addr;
        word_t store;
    } ram_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/RAM bundle around mem_arbiter: master is the requester/RAM side, slave is the arbiter.
// Waits are combinational, so requesters see service in the same cycle the RAM reports ACCESS.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      timeout;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
    );

endinterface

// File: rtl/mem_arb_streak.sv
// Counts consecutive data completions while fetch is pending; ifetch_force overrides data priority.
// Updates one cycle after a completion; no backpressure, purely observes completions.
module mem_arb_streak
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = DSTREAK_MAX_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic icomp,
    input  logic dcomp,
    input  logic iren,
    output logic ifetch_force
);

    logic [2:0] streak;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak <= 3'd0;
        end else if (icomp || (dcomp && !iren)) begin
            streak <= 3'd0;
        end else if (dcomp && streak != 3'd7) begin
            streak <= streak + 3'd1;
        end
    end

    assign ifetch_force = iren && (streak == 3'(DSTREAK_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data: one transaction per grant, DONE bubble after each.
// Grant one cycle after arbitration, holds on BUSY/ERROR; MEMARB_TIMEOUT_EN adds a sticky watchdog abort.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = DSTREAK_MAX_DEF
`ifdef MEMARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    arb_state_t state, state_nxt;
    ram_req_t   req_q;
    logic       dreq, access, in_gnt, icomp, dcomp;
    logic       take_d, take_i, ifetch_force, abort;

    assign dreq   = bus.dREN || bus.dWEN;
    assign access = (bus.ramstate == ACCESS);
    assign in_gnt = (state == IGNT) || (state == DGNT);
    assign icomp  = (state == IGNT) && access;
    assign dcomp  = (state == DGNT) && access;
    assign take_d = (state == IDLE) && dreq && !ifetch_force;
    assign take_i = (state == IDLE) && !take_d && bus.iREN;

    mem_arb_streak #(.DSTREAK_MAX(DSTREAK_MAX)) u_streak (
        .CLK          (CLK),
        .nRST         (nRST),
        .icomp        (icomp),
        .dcomp        (dcomp),
        .iren         (bus.iREN),
        .ifetch_force (ifetch_force)
    );

`ifdef MEMARB_TIMEOUT_EN
    logic [6:0] wd_cnt;
    logic       timeout_q;

    assign abort = in_gnt && !access && (wd_cnt == 7'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wd_cnt    <= 7'd0;
            timeout_q <= 1'b0;
        end else begin
            if (take_d || take_i) begin
                wd_cnt <= 7'd0;
            end else if (in_gnt && !access) begin
                wd_cnt <= wd_cnt + 7'd1;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign abort       = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (take_d) begin
                    state_nxt = DGNT;
                end else if (take_i) begin
                    state_nxt = IGNT;
                end
            end
            // ERROR is not ACCESS, so it simply holds the grant like BUSY.
            IGNT, DGNT: begin
                if (access || abort) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_q <= '0;
        end else if (take_d) begin
            req_q <= '{wen: bus.dWEN, addr: bus.daddr, store: bus.dstore};
        end else if (take_i) begin
            req_q <= '{wen: 1'b0, addr: bus.iaddr, store: '0};
        end
    end

    // Write wins when dREN and dWEN are both set: req_q.wen was latched from dWEN alone.
    assign bus.ramREN   = (state == IGNT) || ((state == DGNT) && !req_q.wen);
    assign bus.ramWEN   = (state == DGNT) && req_q.wen;
    assign bus.ramaddr  = in_gnt ? req_q.addr  : '0;
    assign bus.ramstore = in_gnt ? req_q.store : '0;

    // A dropped request sees wait=0 and a zero load; its RAM result is discarded.
    assign bus.iwait = bus.iREN && !icomp;
    assign bus.dwait = dreq && !dcomp;
    assign bus.iload = (bus.iREN && icomp) ? bus.ramload : '0;
    assign bus.dload = (bus.dREN && dcomp) ? bus.ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized requester/RAM environment.
// The reference model tracks whole transactions (who should win, what data comes back).
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int DSMAX = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter #(.DSTREAK_MAX(DSMAX)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  rd;
        logic  wr;
        word_t addr;
        word_t store;
    } dreq_t;

    word_t mem [0:255];
    word_t iq [$];
    dreq_t dq [$];
    logic  i_pend, d_pend, prev_en, prev_i, prev_d, just_done;
    word_t i_cur;
    dreq_t d_cur;
    int    m_streak, lat, n_served;
    byte   cur_g;
    string glog;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
        bus.ramload = 0; bus.ramstate = FREE;
        nRST = 0;
        tick();
        tick();
        nRST = 1;
    endtask

    task automatic test_reset();
        logic [132:0] obs;
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = 32'h1234; bus.daddr = 32'h5678; bus.dstore = 32'h9abc;
        bus.ramload = 32'hffff_ffff; bus.ramstate = ACCESS;
        nRST = 0;
        #1;
        obs = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.timeout,
               bus.iwait, bus.dwait, bus.iload, bus.dload};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", obs);
        end
        bus.iREN = 1; bus.dREN = 1;
        tick();
        checks++;
        if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_waits got %b want 1100", {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN});
        end
    endtask

    task automatic test_ifetch();
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h40;
        #1;
        checks++;
        if ({bus.ramREN, bus.iwait} !== 2'b01) begin
            errors++;
            $display("FAIL ifetch_idle got %b want 01", {bus.ramREN, bus.iwait});
        end
        tick(); bus.ramstate = BUSY; bus.ramload = 32'h1111_2222; #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload} !== {2'b10, 32'h40, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL ifetch_busy got ren=%b wen=%b addr=%h iwait=%b iload=%h want 1 0 40 1 0",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload);
        end
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h8C22_0004; #1;
        checks++;
        if ({bus.iwait, bus.iload} !== {1'b0, 32'h8C22_0004}) begin
            errors++;
            $display("FAIL ifetch_access got iwait=%b iload=%h want 0 8c220004", bus.iwait, bus.iload);
        end
        tick(); bus.iREN = 0; bus.ramstate = FREE; #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin
            errors++;
            $display("FAIL ifetch_done_bubble got %b want 00", {bus.ramREN, bus.ramWEN});
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h80;
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        #1;
        tick(); bus.ramstate = ACCESS; #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, bus.iwait} !==
            {2'b01, 32'h100, 32'hDEAD_BEEF, 2'b01}) begin
            errors++;
            $display("FAIL prio_data_first got ren=%b wen=%b addr=%h store=%h dwait=%b iwait=%b",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, bus.iwait);
        end
        tick(); bus.dWEN = 0; bus.ramstate = FREE; #1;
        tick(); #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait} !== 3'b001) begin
            errors++;
            $display("FAIL prio_gap got %b want 001", {bus.ramREN, bus.ramWEN, bus.iwait});
        end
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h0BAD_F00D; #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload} !== {1'b1, 32'h80, 1'b0, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL prio_ifetch_after got ren=%b addr=%h iwait=%b iload=%h",
                     bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
        end
        tick(); bus.iREN = 0; bus.ramstate = FREE;
    endtask

    task automatic test_rw_both();
        do_reset();
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h1234_5678;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.ramstate = (c == 1) ? ERROR : BUSY;
            bus.ramload = 32'hAAAA_5555;
            #1;
            checks++;
            if ({bus.ramREN, bus.ramWEN, bus.dwait, bus.dload} !== {3'b011, 32'h0}) begin
                errors++;
                $display("FAIL rw_both_hold c=%0d got ren=%b wen=%b dwait=%b dload=%h want 0 1 1 0",
                         c, bus.ramREN, bus.ramWEN, bus.dwait, bus.dload);
            end
        end
        tick(); bus.ramstate = ACCESS; #1;
        checks++;
        if ({bus.ramWEN, bus.dwait} !== 2'b10) begin
            errors++;
            $display("FAIL rw_both_done got wen=%b dwait=%b want 1 0", bus.ramWEN, bus.dwait);
        end
        tick(); bus.dREN = 0; bus.dWEN = 0; bus.ramstate = FREE;
    endtask

    task automatic test_drop();
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h44;
        #1;
        tick(); bus.ramstate = BUSY; bus.iREN = 0; #1;
        checks++;
        if ({bus.ramREN, bus.iwait} !== 2'b10) begin
            errors++;
            $display("FAIL drop_busy got ren=%b iwait=%b want 1 0", bus.ramREN, bus.iwait);
        end
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h5; #1;
        checks++;
        if ({bus.ramREN, bus.iwait, bus.iload} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL drop_access got ren=%b iwait=%b iload=%h want 1 0 0", bus.ramREN, bus.iwait, bus.iload);
        end
        tick(); bus.ramstate = FREE; #1;
        checks++;
        if (bus.ramREN !== 1'b0) begin
            errors++;
            $display("FAIL drop_bubble got ren=%b want 0", bus.ramREN);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h1;
        #1;
        tick(); bus.ramstate = BUSY; #1;
        checks++;
        if (bus.ramWEN !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant got wen=%b want 1", bus.ramWEN);
        end
        nRST = 0;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.timeout, bus.dwait} !== {67'h0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async got ren=%b wen=%b addr=%h store=%h to=%b dwait=%b",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.timeout, bus.dwait);
        end
        bus.dWEN = 0;
        tick(); nRST = 1; bus.ramstate = FREE;
        bus.iREN = 1; bus.iaddr = 32'h64;
        #1;
        tick(); #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b10, 32'h64}) begin
            errors++;
            $display("FAIL rstmid_restart got ren=%b wen=%b addr=%h want 1 0 64", bus.ramREN, bus.ramWEN, bus.ramaddr);
        end
        bus.iREN = 0;
    endtask

    // One cycle of requester + RAM environment with transaction-level checks.
    task automatic step(input bit gaps, input int lat_max);
        logic         en, acc;
        logic [65:0]  obs, expv;
        tick();
        if (!i_pend && iq.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            i_cur = iq.pop_front(); i_pend = 1;
        end
        if (!d_pend && dq.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            d_cur = dq.pop_front(); d_pend = 1;
        end
        bus.iREN   = i_pend;
        bus.iaddr  = i_pend ? i_cur : $urandom;
        bus.dREN   = d_pend && d_cur.rd;
        bus.dWEN   = d_pend && d_cur.wr;
        bus.daddr  = d_pend ? d_cur.addr : $urandom;
        bus.dstore = d_pend ? d_cur.store : $urandom;
        #1;
        en = bus.ramREN || bus.ramWEN;
        if (en && lat > 0) begin
            bus.ramstate = ($urandom_range(0, 3) == 0) ? ERROR : BUSY;
            bus.ramload  = $urandom;
            lat--;
        end else if (en) begin
            bus.ramstate = ACCESS;
            bus.ramload  = mem[bus.ramaddr[9:2]];
        end else begin
            bus.ramstate = FREE;
            bus.ramload  = $urandom;
            lat = $urandom_range(0, lat_max);
        end
        #1;
        acc = en && (bus.ramstate == ACCESS);
        if (en && !prev_en) begin
            if (prev_d && !(prev_i && m_streak == DSMAX)) cur_g = "D";
            else if (prev_i) cur_g = "I";
            else cur_g = "?";
            glog = $sformatf("%s%c", glog, cur_g);
        end
        if (en) begin
            if (cur_g == "D") expv = {~d_cur.wr, d_cur.wr, d_cur.addr, d_cur.store};
            else if (cur_g == "I") expv = {2'b10, i_cur, 32'h0};
            else expv = '1;
            obs = {bus.ramREN, bus.ramWEN, bus.ramaddr, (cur_g == "I") ? 32'h0 : bus.ramstore};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL ram_req grant=%c got %h want %h", cur_g, obs, expv);
            end
        end
        if (just_done) begin
            checks++;
            if (en !== 1'b0) begin
                errors++;
                $display("FAIL done_bubble got en=%b want 0", en);
            end
        end
        expv = {i_pend && !(acc && cur_g == "I"), d_pend && !(acc && cur_g == "D"),
                (acc && cur_g == "I" && i_pend) ? mem[i_cur[9:2]] : 32'h0,
                (acc && cur_g == "D" && d_pend && d_cur.rd) ? mem[d_cur.addr[9:2]] : 32'h0};
        obs = {bus.iwait, bus.dwait, bus.iload, bus.dload};
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL wait_load grant=%c got %h want %h", cur_g, obs, expv);
        end
        just_done = acc;
        prev_en   = en;
        prev_i    = i_pend;
        prev_d    = d_pend;
        if (acc && cur_g == "D") begin
            if (d_cur.wr) mem[d_cur.addr[9:2]] = d_cur.store;
            m_streak = i_pend ? ((m_streak < 7) ? m_streak + 1 : 7) : 0;
            d_pend = 0;
            n_served++;
        end else if (acc && cur_g == "I") begin
            m_streak = 0;
            i_pend = 0;
            n_served++;
        end
    endtask

    task automatic run_engine(input bit gaps, input int lat_max, input int budget);
        int cyc;
        int total;
        cyc = 0;
        total = iq.size() + dq.size();
        do_reset();
        i_pend = 0; d_pend = 0; prev_en = 0; prev_i = 0; prev_d = 0; just_done = 0;
        m_streak = 0; lat = 0; n_served = 0; glog = "";
        while ((iq.size() > 0 || dq.size() > 0 || i_pend || d_pend) && cyc < budget) begin
            step(gaps, lat_max);
            cyc++;
        end
        checks++;
        if (n_served !== total) begin
            errors++;
            $display("FAIL engine_drain served %0d want %0d after %0d cycles", n_served, total, cyc);
        end
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    endtask

    task automatic test_streak();
        dreq_t r;
        iq.delete(); dq.delete();
        for (int k = 0; k < 3; k++) iq.push_back(32'(4 * k));
        for (int k = 0; k < 6; k++) begin
            r.rd = 1; r.wr = 0; r.addr = 32'h100 + 32'(4 * k); r.store = $urandom;
            dq.push_back(r);
        end
        run_engine(1'b0, 1, 500);
        checks++;
        if (glog != "DDDDIDDII") begin
            errors++;
            $display("FAIL streak_order got %s want DDDDIDDII", glog);
        end
    endtask

    task automatic test_random();
        dreq_t r;
        int    op;
        iq.delete(); dq.delete();
        for (int k = 0; k < 40; k++) begin
            iq.push_back({22'h0, 8'($urandom), 2'b00});
            op = $urandom_range(1, 3);
            r.rd = op[0]; r.wr = op[1];
            r.addr = {22'h0, 8'($urandom), 2'b00};
            r.store = $urandom;
            dq.push_back(r);
        end
        run_engine(1'b1, 3, 5000);
    endtask

    task automatic test_timeout();
        int en_cnt, first_drop, regrant;
        bit iw_low;
        en_cnt = 0; first_drop = -1; regrant = -1; iw_low = 0;
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h48;
        #1;
        for (int c = 1; c <= 70; c++) begin
            tick(); bus.ramstate = BUSY; #1;
            if (bus.ramREN && first_drop < 0) en_cnt++;
            else if (!bus.ramREN && first_drop < 0) first_drop = c;
            else if (bus.ramREN && first_drop >= 0 && regrant < 0) regrant = c;
            if (!bus.iwait) iw_low = 1;
        end
        checks++;
`ifdef MEMARB_TIMEOUT_EN
        if ({en_cnt, first_drop, regrant, bus.timeout} !== {32'd64, 32'd65, 32'd67, 1'b1}) begin
            errors++;
            $display("FAIL timeout_abort got grant_cycles=%0d drop=%0d regrant=%0d to=%b want 64 65 67 1",
                     en_cnt, first_drop, regrant, bus.timeout);
        end
`else
        if ({en_cnt, first_drop, bus.timeout} !== {32'd70, -32'sd1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_hold got grant_cycles=%0d drop=%0d to=%b want 70 -1 0",
                     en_cnt, first_drop, bus.timeout);
        end
`endif
        checks++;
        if (iw_low !== 1'b0) begin
            errors++;
            $display("FAIL timeout_iwait got early_low=%b want 0", iw_low);
        end
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h77; #1;
        checks++;
`ifdef MEMARB_TIMEOUT_EN
        if ({bus.iwait, bus.iload, bus.timeout} !== {1'b0, 32'h77, 1'b1}) begin
`else
        if ({bus.iwait, bus.iload, bus.timeout} !== {1'b0, 32'h77, 1'b0}) begin
`endif
            errors++;
            $display("FAIL timeout_complete got iwait=%b iload=%h to=%b", bus.iwait, bus.iload, bus.timeout);
        end
        tick(); bus.iREN = 0; bus.ramstate = FREE;
        do_reset();
        #1;
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared got %b want 0", bus.timeout);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        test_reset();
        test_ifetch();
        test_priority();
        test_rw_both();
        test_drop();
        test_reset_mid();
        test_streak();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
